// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the round-robin adder scheduler.
package adder_sched_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sched_state_t;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int id_w(input int reqs);
    return (reqs > 1) ? $clog2(reqs) : 1;
  endfunction

endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int REQS = 4,
  parameter int ID_W = id_w(REQS)
) (
  input  logic [REQS-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [REQS-1:0] grant,
  output logic [ID_W-1:0] winner,
  output logic            found
);

  logic [ID_W-1:0] w_idx;

  // Scan REQS slots upward from ptr; REQS is a power of two, so index
  // arithmetic wraps naturally at ID_W bits.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    w_idx  = '0;
    for (int k = 0; k < REQS; k++) begin
      w_idx = ptr + ID_W'(k);
      if (!found && req[w_idx]) begin
        found  = 1'b1;
        winner = w_idx;
      end
    end
  end

  // One-hot grant, only when the consumer side can take a new result.
  for (genvar gi = 0; gi < REQS; gi++) begin : g_grant
    assign grant[gi] = en & found & (winner == ID_W'(gi));
  end

endmodule

// File: rtl/adder_sched.sv
// Shares one (N+1)-bit adder among REQS requesters through a round-robin
// arbiter, with a single registered result slot under backpressure.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int N    = 4,
  parameter int REQS = 4,
  localparam int ID_W = id_w(REQS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REQS-1:0]     req_valid,
  input  logic [REQS*N-1:0]   req_a,
  input  logic [REQS*N-1:0]   req_b,
  output logic [REQS-1:0]     req_ready,
  output logic                rsp_valid,
  output logic [N-1:0]        rsp_sum,
  output logic                rsp_carry,
  output logic [ID_W-1:0]     rsp_id,
  input  logic                rsp_ready,
  output logic [CNT_W-1:0]    busy_cnt
);

  sched_state_t    r_state;
  sched_state_t    w_state_next;
  logic [ID_W-1:0] r_ptr;
  logic [N-1:0]    r_sum;
  logic            r_carry;
  logic [ID_W-1:0] r_id;
  logic [CNT_W-1:0] r_cnt;

  logic            w_can_accept;
  logic            w_any;
  logic            w_accept;
  logic [ID_W-1:0] w_winner;
  logic [N-1:0]    w_a;
  logic [N-1:0]    w_b;
  logic [N:0]      w_sum;

  // A new result may load when the slot is free or is retiring this edge.
  assign w_can_accept = (r_state == EMPTY) | rsp_ready;

  rr_arbiter #(
    .REQS (REQS),
    .ID_W (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (r_ptr),
    .en     (w_can_accept),
    .grant  (req_ready),
    .winner (w_winner),
    .found  (w_any)
  );

  assign w_accept = w_any & w_can_accept;

  // Only the winner's operands reach the adder; operands are zero-extended
  // so bit N of the sum is the carry-out.
  assign w_a   = req_a[w_winner*N +: N];
  assign w_b   = req_b[w_winner*N +: N];
  assign w_sum = {1'b0, w_a} + {1'b0, w_b};

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_next;
  end

  // Next slot state: load wins over retire so back-to-back stays FULL.
  always_comb begin
    w_state_next = r_state;
    if (w_accept)
      w_state_next = FULL;
    else if ((r_state == FULL) && rsp_ready)
      w_state_next = EMPTY;
  end

  // Result slot, priority pointer and accept counter change only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_id    <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_sum   <= w_sum[N-1:0];
      r_carry <= w_sum[N];
      r_id    <= w_winner;
      r_ptr   <= w_winner + ID_W'(1);
      if (r_cnt != {CNT_W{1'b1}})
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign rsp_valid = (r_state == FULL);
  assign rsp_sum   = r_sum;
  assign rsp_carry = r_carry;
  assign rsp_id    = r_id;
  assign busy_cnt  = r_cnt;

endmodule

// File: tb/tb_adder_sched.sv
// Directed table-driven bench for adder_sched with N=4, REQS=4.
module tb_adder_sched;

  localparam int N    = 4;
  localparam int REQS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [3:0]  rsp_sum;
  logic        rsp_carry;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
  logic [15:0] busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        rr;
    logic [3:0]  exp_rdy;
    logic        exp_v;
    logic [3:0]  exp_sum;
    logic        exp_c;
    logic [1:0]  exp_id;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  adder_sched #(.N(N), .REQS(REQS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy_cnt  (busy_cnt)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] valid, input logic [15:0] a, input logic [15:0] b,
                     input logic rr, input logic [3:0] rdy, input logic v,
                     input logic [3:0] sum, input logic c, input logic [1:0] id,
                     input logic [15:0] cnt);
    vec_t e;
    e.valid = valid; e.a = a; e.b = b; e.rr = rr; e.exp_rdy = rdy;
    e.exp_v = v; e.exp_sum = sum; e.exp_c = c; e.exp_id = id; e.exp_cnt = cnt;
    vecs.push_back(e);
  endtask

  // Drive on the falling edge, check grant mid-cycle, check slot after the edge.
  task automatic run_step(input int idx, input vec_t e);
    @(negedge clk);
    req_valid = e.valid; req_a = e.a; req_b = e.b; rsp_ready = e.rr;
    #1;
    check($sformatf("s%0d req_ready", idx), req_ready, e.exp_rdy);
    @(posedge clk);
    #1;
    check($sformatf("s%0d rsp_valid", idx), rsp_valid, e.exp_v);
    check($sformatf("s%0d rsp_sum", idx), rsp_sum, e.exp_sum);
    check($sformatf("s%0d rsp_carry", idx), rsp_carry, e.exp_c);
    check($sformatf("s%0d rsp_id", idx), rsp_id, e.exp_id);
    check($sformatf("s%0d busy_cnt", idx), busy_cnt, e.exp_cnt);
    $display("step %0d valid=%b rr=%b rdy=%b -> v=%b sum=%h c=%b id=%0d cnt=%0d",
             idx, e.valid, e.rr, e.exp_rdy, rsp_valid, rsp_sum, rsp_carry, rsp_id, busy_cnt);
  endtask

  initial begin
    vec_t e;
    // Round robin from reset: grant order 0,1,2,3,0, back-to-back results.
    for (int i = 0; i < 5; i++)
      add(4'b1111, 16'h4321, 16'h4444, 1'b1, 4'(1 << (i % 4)), 1'b1,
          4'((i % 4) + 5), 1'b0, 2'(i % 4), 16'(i + 1));
    // ptr=1: single request from req 2.
    add(4'b0100, 16'h0300, 16'h0500, 1'b1, 4'b0100, 1'b1, 4'h8, 1'b0, 2'd2, 16'd6);
    // ptr=3: overflow F+1 on req 0, then F+F on req 1.
    add(4'b0001, 16'h000F, 16'h0001, 1'b1, 4'b0001, 1'b1, 4'h0, 1'b1, 2'd0, 16'd7);
    add(4'b0010, 16'h00F0, 16'h00F0, 1'b1, 4'b0010, 1'b1, 4'hE, 1'b1, 2'd1, 16'd8);
    // Idle retires the slot; result fields hold.
    add(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'hE, 1'b1, 2'd1, 16'd8);
    // Grant to req 3 (ptr -> 0), five idle cycles, then req 0 beats req 2.
    add(4'b1000, 16'h7000, 16'h2000, 1'b1, 4'b1000, 1'b1, 4'h9, 1'b0, 2'd3, 16'd9);
    for (int i = 0; i < 5; i++)
      add(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h9, 1'b0, 2'd3, 16'd9);
    add(4'b0101, 16'h0102, 16'h0102, 1'b1, 4'b0001, 1'b1, 4'h4, 1'b0, 2'd0, 16'd10);
    // Backpressure for 3 cycles with req 1 and req 3 waiting: nothing moves.
    for (int i = 0; i < 3; i++)
      add(4'b1010, 16'h3090, 16'h3090, 1'b0, 4'b0000, 1'b1, 4'h4, 1'b0, 2'd0, 16'd10);
    // rsp_ready rises: ptr=1 so req 1 wins in the same cycle (9+9=0x12).
    add(4'b1010, 16'h3090, 16'h3090, 1'b1, 4'b0010, 1'b1, 4'h2, 1'b1, 2'd1, 16'd11);
    add(4'b1000, 16'h3000, 16'h3000, 1'b1, 4'b1000, 1'b1, 4'h6, 1'b0, 2'd3, 16'd12);
    add(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h6, 1'b0, 2'd3, 16'd12);
    // Empty slot accepts even with rsp_ready low; leaves a pending result.
    add(4'b0001, 16'h0001, 16'h0001, 1'b0, 4'b0001, 1'b1, 4'h2, 1'b0, 2'd0, 16'd13);

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset rsp_valid", rsp_valid, 0);
    check("reset busy_cnt", busy_cnt, 0);
    check("reset req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_step(i, vecs[i]);

    // Asynchronous reset mid-cycle while a result is pending (ptr is 1 here).
    @(negedge clk);
    req_valid = 4'b0000; rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rsp_valid", rsp_valid, 0);
    check("async rsp_sum", rsp_sum, 0);
    check("async rsp_carry", rsp_carry, 0);
    check("async rsp_id", rsp_id, 0);
    check("async busy_cnt", busy_cnt, 0);
    $display("async reset applied mid-cycle: v=%b cnt=%0d", rsp_valid, busy_cnt);
    @(negedge clk);
    rst_n = 1'b1;
    // After release the pointer is back at 0, so req 0 wins.
    e.valid = 4'b1111; e.a = 16'h4321; e.b = 16'h4444; e.rr = 1'b1;
    e.exp_rdy = 4'b0001; e.exp_v = 1'b1; e.exp_sum = 4'h5; e.exp_c = 1'b0;
    e.exp_id = 2'd0; e.exp_cnt = 16'd1;
    run_step(100, e);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
